// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared pipeline-control definitions: interrupt FSM states, the NOP encoding
// used for flushed slots, and the default register-address width.
package pipeline_hazard_ctrl_pkg;

    localparam int          REG_ADDR_W = 5;
    localparam logic [31:0] kNOP       = 32'h0000_0013;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        ACK   = 2'd2
    } state_t;

endpackage

// File: rtl/pipeline_hazard_ctrl_hazard_detect.sv
// Load-use comparator between the decode sources and the execute-stage load.
// Latency: purely combinational; no backpressure, the result is consumed the same cycle.
module pipeline_hazard_ctrl_hazard_detect #(
    parameter int REG_ADDR_W = 5
) (
    input  logic [REG_ADDR_W-1:0] i_rs_addr,
    input  logic [REG_ADDR_W-1:0] i_rd_addr,
    input  logic                  i_reads_rs,
    input  logic                  i_reads_rd,
    input  logic                  i_ex_is_load,
    input  logic [REG_ADDR_W-1:0] i_ex_wr_addr,
    output logic                  o_load_use
);
    import pipeline_hazard_ctrl_pkg::*;

    logic w_rs_hit;
    logic w_rd_hit;

    // Register 0 is compared like any other address.
    assign w_rs_hit   = i_reads_rs & (i_rs_addr == i_ex_wr_addr);
    assign w_rd_hit   = i_reads_rd & (i_rd_addr == i_ex_wr_addr);
    assign o_load_use = i_ex_is_load & (w_rs_hit | w_rd_hit);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Per-stage stall/flush/interrupt control plus the interrupt drain sequencer.
// Latency: outputs zero-cycle from inputs and state; mem_busy freezes everything.
module pipeline_hazard_ctrl #(
    parameter int REG_ADDR_W   = pipeline_hazard_ctrl_pkg::REG_ADDR_W,
    parameter int DRAIN_CYCLES = 3
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [REG_ADDR_W-1:0] id_rs_addr,
    input  logic [REG_ADDR_W-1:0] id_rd_addr,
    input  logic                  id_reads_rs,
    input  logic                  id_reads_rd,
    input  logic                  ex_is_load,
    input  logic [REG_ADDR_W-1:0] ex_wr_addr,
    input  logic                  ex_branch_taken,
    input  logic                  mem_busy,
    input  logic                  irq_req,
    output logic                  stall_f2d,
    output logic                  flush_f2d,
    output logic                  stall_d2e,
    output logic                  flush_d2e,
    output logic                  itr_d2e,
    output logic                  pc_sel_irq,
    output logic                  irq_ack
);
    import pipeline_hazard_ctrl_pkg::*;

    localparam int               CNT_W    = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(DRAIN_CYCLES - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_load_use;

    pipeline_hazard_ctrl_hazard_detect #(
        .REG_ADDR_W (REG_ADDR_W)
    ) u_hazard_detect (
        .i_rs_addr    (id_rs_addr),
        .i_rd_addr    (id_rd_addr),
        .i_reads_rs   (id_reads_rs),
        .i_reads_rd   (id_reads_rd),
        .i_ex_is_load (ex_is_load),
        .i_ex_wr_addr (ex_wr_addr),
        .o_load_use   (w_load_use)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= RUN;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        stall_f2d   = 1'b0;
        flush_f2d   = 1'b0;
        stall_d2e   = 1'b0;
        flush_d2e   = 1'b0;
        itr_d2e     = 1'b0;
        pc_sel_irq  = 1'b0;
        irq_ack     = 1'b0;
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;

        if (mem_busy) begin
            stall_f2d = 1'b1;
            stall_d2e = 1'b1;
        end else begin
            case (r_state)
                RUN: begin
                    // A redirect or load-use bubble this cycle defers interrupt entry.
                    if (ex_branch_taken) begin
                        flush_f2d = 1'b1;
                        flush_d2e = 1'b1;
                    end else if (w_load_use) begin
                        stall_f2d = 1'b1;
                        flush_d2e = 1'b1;
                    end else if (irq_req) begin
                        w_state_nxt = DRAIN;
                        w_cnt_nxt   = CNT_INIT;
                    end
                end
                DRAIN: begin
                    stall_f2d = 1'b1;
                    itr_d2e   = 1'b1;
                    // The branch target is discarded anyway once the vector is taken.
                    if (ex_branch_taken) begin
                        flush_f2d = 1'b1;
                        flush_d2e = 1'b1;
                    end
                    if (r_cnt == '0) begin
                        w_state_nxt = ACK;
                    end else begin
                        w_cnt_nxt = r_cnt - CNT_W'(1);
                    end
                end
                ACK: begin
                    irq_ack     = 1'b1;
                    pc_sel_irq  = 1'b1;
                    flush_f2d   = 1'b1;
                    itr_d2e     = 1'b1;
                    flush_d2e   = ex_branch_taken;
                    w_state_nxt = RUN;
                end
                default: begin
                    w_state_nxt = RUN;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scenario bench for pipeline_hazard_ctrl with an expected-output queue.
module tb_pipeline_hazard_ctrl;

    localparam int AW = 5;

    // Output word: {stall_f2d, flush_f2d, stall_d2e, flush_d2e, itr_d2e, pc_sel_irq, irq_ack}
    localparam logic [6:0] O_IDLE     = 7'b0000000;
    localparam logic [6:0] O_LU       = 7'b1001000;
    localparam logic [6:0] O_BR       = 7'b0101000;
    localparam logic [6:0] O_BUSY     = 7'b1010000;
    localparam logic [6:0] O_DRAIN    = 7'b1000100;
    localparam logic [6:0] O_DRAIN_BR = 7'b1101100;
    localparam logic [6:0] O_ACK      = 7'b0100111;

    // Stimulus word: {ex_is_load, ex_branch_taken, mem_busy, irq_req}
    localparam logic [3:0] S_IDLE = 4'b0000;
    localparam logic [3:0] S_LOAD = 4'b1000;
    localparam logic [3:0] S_BR   = 4'b0100;
    localparam logic [3:0] S_BUSY = 4'b0010;
    localparam logic [3:0] S_IRQ  = 4'b0001;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [AW-1:0] id_rs_addr;
    logic [AW-1:0] id_rd_addr;
    logic          id_reads_rs;
    logic          id_reads_rd;
    logic          ex_is_load;
    logic [AW-1:0] ex_wr_addr;
    logic          ex_branch_taken;
    logic          mem_busy;
    logic          irq_req;
    logic          stall_f2d;
    logic          flush_f2d;
    logic          stall_d2e;
    logic          flush_d2e;
    logic          itr_d2e;
    logic          pc_sel_irq;
    logic          irq_ack;

    logic [6:0] exp_q[$];
    int         checks = 0;
    int         errors = 0;

    pipeline_hazard_ctrl #(
        .REG_ADDR_W   (AW),
        .DRAIN_CYCLES (3)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .id_rs_addr      (id_rs_addr),
        .id_rd_addr      (id_rd_addr),
        .id_reads_rs     (id_reads_rs),
        .id_reads_rd     (id_reads_rd),
        .ex_is_load      (ex_is_load),
        .ex_wr_addr      (ex_wr_addr),
        .ex_branch_taken (ex_branch_taken),
        .mem_busy        (mem_busy),
        .irq_req         (irq_req),
        .stall_f2d       (stall_f2d),
        .flush_f2d       (flush_f2d),
        .stall_d2e       (stall_d2e),
        .flush_d2e       (flush_d2e),
        .itr_d2e         (itr_d2e),
        .pc_sel_irq      (pc_sel_irq),
        .irq_ack         (irq_ack)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] outs();
        return {stall_f2d, flush_f2d, stall_d2e, flush_d2e, itr_d2e, pc_sel_irq, irq_ack};
    endfunction

    task automatic apply(input logic [3:0] s);
        {ex_is_load, ex_branch_taken, mem_busy, irq_req} = s;
    endtask

    task automatic set_addr(input logic rrs, input logic rrd, input logic [AW-1:0] rs,
                            input logic [AW-1:0] rd, input logic [AW-1:0] wr);
        id_reads_rs = rrs;
        id_reads_rd = rrd;
        id_rs_addr  = rs;
        id_rd_addr  = rd;
        ex_wr_addr  = wr;
    endtask

    task automatic test_reset();
        logic [6:0] got;
        logic [6:0] e;
        reset_n = 1'b0;
        apply(S_IRQ);
        set_addr(1'b1, 1'b0, 5'd3, 5'd7, 5'd3);
        #3;
        exp_q.push_back(O_IDLE);
        got = outs(); e = exp_q.pop_front(); checks++;
        if (got !== e) begin errors++; $display("FAIL reset_pre_edge got %b exp %b", got, e); end
        #5;
        exp_q.push_back(O_IDLE);
        got = outs(); e = exp_q.pop_front(); checks++;
        if (got !== e) begin errors++; $display("FAIL reset_post_edge got %b exp %b", got, e); end
        apply(S_IDLE);
        #4 reset_n = 1'b1;
    endtask

    task automatic test_load_use();
        logic [3:0] st[$];
        logic [6:0] ex[$];
        logic [6:0] got;
        logic [6:0] e;
        st = '{S_LOAD, S_IDLE};
        ex = '{O_LU, O_IDLE};
        set_addr(1'b1, 1'b0, 5'd3, 5'd7, 5'd3);
        for (int k = 0; k < st.size(); k++) begin
            @(posedge clk); #1; apply(st[k]); exp_q.push_back(ex[k]);
            @(negedge clk); got = outs(); e = exp_q.pop_front(); checks++;
            if (got !== e) begin errors++; $display("FAIL load_use step %0d got %b exp %b", k, got, e); end
        end
    endtask

    task automatic test_addr_match();
        logic [16:0] cfg[$];
        logic [3:0]  st[$];
        logic [6:0]  ex[$];
        logic [6:0]  got;
        logic [6:0]  e;
        logic [16:0] c;
        // cfg: {reads_rs, reads_rd, rs, rd, wr}
        cfg = '{{2'b10, 5'd0, 5'd9, 5'd0}, {2'b01, 5'd5, 5'd12, 5'd12},
                {2'b11, 5'd4, 5'd6, 5'd5}, {2'b00, 5'd5, 5'd5, 5'd5},
                {2'b10, 5'd5, 5'd1, 5'd5}};
        st  = '{S_LOAD, S_LOAD, S_LOAD, S_LOAD, S_IDLE};
        ex  = '{O_LU, O_LU, O_IDLE, O_IDLE, O_IDLE};
        for (int k = 0; k < st.size(); k++) begin
            @(posedge clk); #1;
            c = cfg[k];
            set_addr(c[16], c[15], c[14:10], c[9:5], c[4:0]);
            apply(st[k]); exp_q.push_back(ex[k]);
            @(negedge clk); got = outs(); e = exp_q.pop_front(); checks++;
            if (got !== e) begin errors++; $display("FAIL addr_match step %0d got %b exp %b", k, got, e); end
        end
        set_addr(1'b1, 1'b0, 5'd3, 5'd7, 5'd3);
    endtask

    task automatic test_branch_over_load();
        logic [3:0] st[$];
        logic [6:0] ex[$];
        logic [6:0] got;
        logic [6:0] e;
        st = '{S_LOAD | S_BR, S_BR, S_IDLE};
        ex = '{O_BR, O_BR, O_IDLE};
        for (int k = 0; k < st.size(); k++) begin
            @(posedge clk); #1; apply(st[k]); exp_q.push_back(ex[k]);
            @(negedge clk); got = outs(); e = exp_q.pop_front(); checks++;
            if (got !== e) begin errors++; $display("FAIL branch_over_load step %0d got %b exp %b", k, got, e); end
        end
    endtask

    task automatic test_irq_seq();
        logic [3:0] st[$];
        logic [6:0] ex[$];
        logic [6:0] got;
        logic [6:0] e;
        st = '{S_IRQ, S_IDLE, S_IDLE, S_IDLE, S_IDLE, S_IDLE};
        ex = '{O_IDLE, O_DRAIN, O_DRAIN, O_DRAIN, O_ACK, O_IDLE};
        for (int k = 0; k < st.size(); k++) begin
            @(posedge clk); #1; apply(st[k]); exp_q.push_back(ex[k]);
            @(negedge clk); got = outs(); e = exp_q.pop_front(); checks++;
            if (got !== e) begin errors++; $display("FAIL irq_seq step %0d got %b exp %b", k, got, e); end
        end
    endtask

    task automatic test_mem_busy_drain();
        logic [3:0] st[$];
        logic [6:0] ex[$];
        logic [6:0] got;
        logic [6:0] e;
        st = '{S_IRQ, S_IDLE, S_BUSY, S_BUSY | S_IRQ, S_IDLE, S_IDLE, S_BUSY, S_IDLE, S_IDLE};
        ex = '{O_IDLE, O_DRAIN, O_BUSY, O_BUSY, O_DRAIN, O_DRAIN, O_BUSY, O_ACK, O_IDLE};
        for (int k = 0; k < st.size(); k++) begin
            @(posedge clk); #1; apply(st[k]); exp_q.push_back(ex[k]);
            @(negedge clk); got = outs(); e = exp_q.pop_front(); checks++;
            if (got !== e) begin errors++; $display("FAIL mem_busy_drain step %0d got %b exp %b", k, got, e); end
        end
    endtask

    task automatic test_irq_with_load_use();
        logic [3:0] st[$];
        logic [6:0] ex[$];
        logic [6:0] got;
        logic [6:0] e;
        st = '{S_IRQ | S_BR, S_IRQ | S_LOAD, S_IRQ, S_IDLE, S_IDLE, S_IDLE, S_IDLE, S_IDLE};
        ex = '{O_BR, O_LU, O_IDLE, O_DRAIN, O_DRAIN, O_DRAIN, O_ACK, O_IDLE};
        for (int k = 0; k < st.size(); k++) begin
            @(posedge clk); #1; apply(st[k]); exp_q.push_back(ex[k]);
            @(negedge clk); got = outs(); e = exp_q.pop_front(); checks++;
            if (got !== e) begin errors++; $display("FAIL irq_with_load_use step %0d got %b exp %b", k, got, e); end
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] st[$];
        logic [6:0] ex[$];
        logic [6:0] got;
        logic [6:0] e;
        st = '{S_IRQ, S_IRQ | S_BR, S_IRQ, S_IRQ, S_IRQ, S_IRQ,
               S_IDLE, S_IDLE, S_LOAD, S_IDLE, S_IDLE};
        ex = '{O_IDLE, O_DRAIN_BR, O_DRAIN, O_DRAIN, O_ACK, O_IDLE,
               O_DRAIN, O_DRAIN, O_DRAIN, O_ACK, O_IDLE};
        for (int k = 0; k < st.size(); k++) begin
            @(posedge clk); #1; apply(st[k]); exp_q.push_back(ex[k]);
            @(negedge clk); got = outs(); e = exp_q.pop_front(); checks++;
            if (got !== e) begin errors++; $display("FAIL back_to_back step %0d got %b exp %b", k, got, e); end
        end
    endtask

    task automatic test_reset_mid_drain();
        logic [6:0] got;
        logic [6:0] e;
        @(posedge clk); #1; apply(S_IRQ); exp_q.push_back(O_IDLE);
        @(negedge clk); got = outs(); e = exp_q.pop_front(); checks++;
        if (got !== e) begin errors++; $display("FAIL rst_mid_entry got %b exp %b", got, e); end
        @(posedge clk); #1; apply(S_IDLE); exp_q.push_back(O_DRAIN);
        @(negedge clk); got = outs(); e = exp_q.pop_front(); checks++;
        if (got !== e) begin errors++; $display("FAIL rst_mid_drain got %b exp %b", got, e); end
        #2 reset_n = 1'b0;
        #1 exp_q.push_back(O_IDLE);
        got = outs(); e = exp_q.pop_front(); checks++;
        if (got !== e) begin errors++; $display("FAIL rst_mid_async got %b exp %b", got, e); end
        @(posedge clk); #1 reset_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            exp_q.push_back(O_IDLE);
            @(negedge clk); got = outs(); e = exp_q.pop_front(); checks++;
            if (got !== e) begin errors++; $display("FAIL rst_mid_after step %0d got %b exp %b", k, got, e); end
        end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_addr_match();
        test_branch_over_load();
        test_irq_seq();
        test_mem_busy_drain();
        test_irq_with_load_use();
        test_back_to_back();
        test_reset_mid_drain();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

endmodule
